// File: rtl/cg_memory_beh_if.sv
// Purpose : write + read channel bundle for the cg_memory_beh word memory.
// Latency : n/a (wires only).
// Backpressure: wready / arready gate requests; rready holds the read response.
// Signals : wen/wvalid/wready/waddr/wdata (+wstrb when CG_MEM_WSTRB_EN),
//           arvalid/arready/araddr, rvalid/rdata/rready.
interface cg_memory_beh_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    wen;
  logic                    wvalid;
  logic                    wready;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [DATA_WIDTH-1:0]   wdata;
`ifdef CG_MEM_WSTRB_EN
  logic [DATA_WIDTH/8-1:0] wstrb;
`endif
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rready;

  modport master (
`ifdef CG_MEM_WSTRB_EN
    output wstrb,
`endif
    output wen, wvalid, waddr, wdata, arvalid, araddr, rready,
    input  wready, arready, rvalid, rdata
  );

  modport slave (
`ifdef CG_MEM_WSTRB_EN
    input  wstrb,
`endif
    input  wen, wvalid, waddr, wdata, arvalid, araddr, rready,
    output wready, arready, rvalid, rdata
  );
endinterface

// File: rtl/cg_memory_beh.sv
// Purpose : behavioural flop-array word memory (instruction/data RAM model).
// Latency : write visible to reads accepted on the following edge; read data 1 cycle after accept.
// Backpressure: single response register; arready drops while a response waits for rready.
// Ports   : clk, rst_n (async active-low), mem_if (cg_memory_beh_if.slave).
// Option  : CG_MEM_WSTRB_EN adds per-byte write strobes (DATA_WIDTH multiple of 8).
// Params  : WORD_NUM must be a power of two >= 2; addresses are word addresses
//           and wrap modulo WORD_NUM (upper address bits ignored).
module cg_memory_beh #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_NUM   = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  cg_memory_beh_if.slave   mem_if
);
  localparam int IDX_W = $clog2(WORD_NUM);

  // Storage starts zeroed and is deliberately never touched by rst_n.
  logic [DATA_WIDTH-1:0] mem_q [WORD_NUM] = '{default: '0};

  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
  logic [DATA_WIDTH-1:0] wr_word_d;

  logic                  wr_fire;
  logic                  rd_fire;
  logic [IDX_W-1:0]      widx;
  logic [IDX_W-1:0]      ridx;

  assign widx = mem_if.waddr[IDX_W-1:0];
  assign ridx = mem_if.araddr[IDX_W-1:0];

  // Upper address bits only select aliases of the same word.
  generate
    if (ADDR_WIDTH > IDX_W) begin : g_unused_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^{mem_if.waddr[ADDR_WIDTH-1:IDX_W],
                                  mem_if.araddr[ADDR_WIDTH-1:IDX_W]};
    end
  endgenerate

  // Write channel never stalls outside reset.
  assign mem_if.wready  = rst_n;
  // Response register frees up either when empty or when drained this edge.
  assign mem_if.arready = rst_n & (~rvalid_q | mem_if.rready);

  assign wr_fire = mem_if.wen & mem_if.wvalid & mem_if.wready;
  assign rd_fire = mem_if.arvalid & mem_if.arready;

  assign mem_if.rvalid = rvalid_q;
  assign mem_if.rdata  = rdata_q;

  // Word to be stored on a committed write.
  always_comb begin
    wr_word_d = mem_if.wdata;
`ifdef CG_MEM_WSTRB_EN
    wr_word_d = mem_q[widx];
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      if (mem_if.wstrb[b]) begin
        wr_word_d[b*8 +: 8] = mem_if.wdata[b*8 +: 8];
      end
    end
`endif
  end

  // Array write; no reset on purpose so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[widx] <= wr_word_d;
    end
  end

  // Read response next-state. The array is sampled before this edge's write
  // lands, which gives read-before-write on an index collision.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = mem_q[ridx];
    end else if (mem_if.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end
endmodule

// File: tb/tb_cg_memory_beh.sv
// Purpose : self-checking bench for cg_memory_beh (scoreboard + directed tasks).
// Latency : n/a.
// Backpressure: exercises rready stalls, back-to-back reads and async reset.
module tb_cg_memory_beh;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int WN = 1024;
  localparam int IW = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cg_memory_beh_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cg_memory_beh #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORD_NUM(WN)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mem_if (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model [WN];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] sb_exp;

  // Scoreboard: outputs sampled mid-cycle. Order inside the block gives the
  // model read-before-write: a read accepted this edge sees the old word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rvalid && bus.rready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: rdata=%h but no read pending", bus.rdata);
        end else begin
          sb_exp = exp_q.pop_front();
          if (bus.rdata !== sb_exp) begin
            errors++;
            $display("FAIL sb_rdata: got %h expected %h", bus.rdata, sb_exp);
          end
        end
      end
      if (bus.arvalid && bus.arready)
        exp_q.push_back(model[bus.araddr[IW-1:0]]);
      if (bus.wen && bus.wvalid && bus.wready) begin
`ifdef CG_MEM_WSTRB_EN
        for (int b = 0; b < DW/8; b++)
          if (bus.wstrb[b]) model[bus.waddr[IW-1:0]][b*8 +: 8] = bus.wdata[b*8 +: 8];
`else
        model[bus.waddr[IW-1:0]] = bus.wdata;
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic en, input logic vld);
    bus.wen = en; bus.wvalid = vld; bus.waddr = a; bus.wdata = d;
    @(negedge clk);
    chk("wready_during_write", {31'b0, bus.wready}, 32'd1);
    step();
    bus.wen = 1'b0; bus.wvalid = 1'b0;
    step();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] expv, input string name);
    bus.arvalid = 1'b1; bus.araddr = a; bus.rready = 1'b1;
    step();
    bus.arvalid = 1'b0;
    @(negedge clk);
    chk({name, "_rvalid"}, {31'b0, bus.rvalid}, 32'd1);
    chk({name, "_rdata"}, bus.rdata, expv);
    step();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rvalid",  {31'b0, bus.rvalid},  32'd0);
    chk("rst_rdata",   bus.rdata,            32'd0);
    chk("rst_wready",  {31'b0, bus.wready},  32'd0);
    chk("rst_arready", {31'b0, bus.arready}, 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_wready",  {31'b0, bus.wready},  32'd1);
    chk("post_rst_arready", {31'b0, bus.arready}, 32'd1);
    step();
  endtask

  task automatic test_write();
    do_write(32'h514, 32'h114, 1'b1, 1'b1);
    do_write(32'h515, 32'h214, 1'b1, 1'b1);
    do_write(32'h516, 32'hAAAA_AAAA, 1'b1, 1'b1);
  endtask

  task automatic test_read();
    do_read(32'h514, 32'h114, "rd_514");
    @(negedge clk);
    chk("rvalid_drop", {31'b0, bus.rvalid}, 32'd0);
    chk("rdata_hold_idle", bus.rdata, 32'h114);
    step();
    do_read(32'h515, 32'h214, "rd_515");
    do_read(32'h516, 32'hAAAA_AAAA, "rd_516");
  endtask

  task automatic test_rbw();
    bus.arvalid = 1'b1; bus.araddr = 32'h516; bus.rready = 1'b1;
    bus.wen = 1'b1; bus.wvalid = 1'b1; bus.waddr = 32'h516; bus.wdata = 32'h314;
    step();
    bus.arvalid = 1'b0; bus.wen = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    chk("rbw_old_data", bus.rdata, 32'hAAAA_AAAA);
    step();
    do_read(32'h516, 32'h314, "rbw_new_data");
  endtask

  task automatic test_wen_gating_alias();
    do_write(32'h514, 32'hDEAD, 1'b0, 1'b1);
    do_write(32'h514, 32'hBEEF, 1'b1, 1'b0);
    do_read(32'h514, 32'h114, "gated_write");
    do_write(32'h914, 32'h55, 1'b1, 1'b1);
    do_read(32'h514, 32'h55, "alias_write");
  endtask

  task automatic test_backpressure();
    bus.rready = 1'b0; bus.arvalid = 1'b1; bus.araddr = 32'h515;
    step();
    bus.araddr = 32'h516;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_arready", {31'b0, bus.arready}, 32'd0);
      chk("stall_rvalid",  {31'b0, bus.rvalid},  32'd1);
      chk("stall_rdata",   bus.rdata,            32'h214);
      step();
    end
    bus.rready = 1'b1;
    @(negedge clk);
    chk("drain_arready", {31'b0, bus.arready}, 32'd1);
    step();
    bus.arvalid = 1'b0;
    @(negedge clk);
    chk("reload_rvalid", {31'b0, bus.rvalid}, 32'd1);
    chk("reload_rdata",  bus.rdata,           32'h314);
    step();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a [4];
    logic [DW-1:0] e [4];
    a = '{32'h514, 32'h515, 32'h516, 32'h514};
    e = '{32'h55, 32'h214, 32'h314, 32'h55};
    bus.rready = 1'b1; bus.arvalid = 1'b1; bus.araddr = a[0];
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) bus.araddr = a[i+1];
      else       bus.arvalid = 1'b0;
      @(negedge clk);
      chk("b2b_rvalid", {31'b0, bus.rvalid}, 32'd1);
      chk("b2b_rdata",  bus.rdata,           e[i]);
    end
    step();
  endtask

  task automatic test_async_reset();
    bus.rready = 1'b0; bus.arvalid = 1'b1; bus.araddr = 32'h515;
    step();
    bus.arvalid = 1'b0;
    @(negedge clk);
    chk("pre_arst_rvalid", {31'b0, bus.rvalid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rvalid",  {31'b0, bus.rvalid},  32'd0);
    chk("arst_rdata",   bus.rdata,            32'd0);
    chk("arst_arready", {31'b0, bus.arready}, 32'd0);
    chk("arst_wready",  {31'b0, bus.wready},  32'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
    do_read(32'h515, 32'h214, "kept_515");
    do_read(32'h514, 32'h55,  "kept_514");
  endtask

  initial begin
    for (int i = 0; i < WN; i++) model[i] = '0;
    bus.wen = 1'b0; bus.wvalid = 1'b0; bus.waddr = '0; bus.wdata = '0;
`ifdef CG_MEM_WSTRB_EN
    bus.wstrb = '1;
`endif
    bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;

    test_reset();
    test_write();
    test_read();
    test_rbw();
    test_wen_gating_alias();
    test_backpressure();
    test_back_to_back();
    test_async_reset();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d responses pending, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cg_memory_beh.md
Name: cg_memory_beh

Overview:
- Behavioural, single-port-per-direction word memory used as a simulation model of instruction/data RAM.
- Sits behind the CG_memory_interface bundle.
  - Write channel: wen/wvalid/waddr/wdata.
  - Read channel: AXI-lite-style araddr/arvalid request and rdata/rvalid/rready response.
- Not intended for synthesis to real SRAM. The RTL must still be synthesizable-style (flop array).

Parameters:
- DATA_WIDTH, 32: width of one memory word and of wdata/rdata.
- ADDR_WIDTH, 32: width of waddr/araddr.
- WORD_NUM, 1024: number of words.
  - Must be a power of two, 2 or more.
  - IDX_W = $clog2(WORD_NUM).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wen  in  1  write enable.
- wvalid  in  1  write request valid.
- wready  out  1  write channel ready.
- waddr  in  ADDR_WIDTH  word address of write.
- wdata  in  DATA_WIDTH  write data.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- araddr  in  ADDR_WIDTH  word address of read.
- rvalid  out  1  read data valid.
- rdata  out  DATA_WIDTH  read data.
- rready  in  1  read data accepted by master.

Behaviour:
- Addressing:
  - Addresses are word addresses, not byte addresses.
  - Array index = addr[IDX_W-1:0]. Upper bits are ignored, so addresses wrap modulo WORD_NUM (0x514 -> index 0x114).
  - Consecutive addresses hit consecutive words.
- Contents:
  - Array is initialised to all-zero at time 0.
  - rst_n does NOT clear the array. Only control/output registers are reset.
- Reset (rst_n=0, asynchronous):
  - rvalid=0, rdata=0.
  - wready=0 and arready=0 while rst_n=0.
  - Any request in flight is dropped.
- Write:
  - wready=1 whenever rst_n=1.
  - A write commits at the rising edge where wen & wvalid & wready = 1: mem[idx(waddr)] <= wdata.
  - wen=1 with wvalid=0, or wvalid=1 with wen=0, writes nothing.
  - Write latency: data is visible to a read accepted on the next edge or later.
- Read:
  - Single-entry response register.
  - arready = rst_n & (!rvalid | rready).
  - Read accepted at the edge where arvalid & arready = 1. At that edge: rdata <= mem[idx(araddr)], rvalid <= 1. One-cycle latency.
  - rvalid with rdata held stable until a rising edge with rready=1.
  - At that edge, rvalid drops unless a new read is accepted in the same edge; a new acceptance reloads rdata and keeps rvalid=1 (back-to-back throughput 1 read/cycle).
  - rready with rvalid=0 has no effect.
  - rdata keeps its last value when rvalid=0.
- Simultaneous read and write to same index on the same edge:
  - Read returns the OLD contents (read-before-write).
  - The write still commits.
- Simultaneous read and write to different indices: both proceed independently.
- No error responses. All addresses are legal.

Optional Feature:
- Macro CG_MEM_WSTRB_EN.
- When defined:
  - Adds input port wstrb, width DATA_WIDTH/8.
  - On a committed write, only bytes whose wstrb bit is 1 are updated; other bytes are retained.
  - DATA_WIDTH must be a multiple of 8.
- When undefined:
  - No wstrb port.
  - Every committed write replaces the full word.

Test Plan:
- Reset, then write 0x114 to 0x514, 0x214 to 0x515, 0xAAAAAAAA to 0x516 (wen=wvalid=1, one cycle each, idle cycle between) -> wready=1 throughout. Later reads of the three addresses return 0x114, 0x214, 0xAAAAAAAA respectively.
- Read 0x514 (arvalid=rready=1 for one cycle) -> rvalid=1 and rdata=0x114 one cycle after acceptance. rvalid drops after the edge with rready=1.
- Same-cycle read of 0x516 and write 0x314 to 0x516 -> that read returns 0xAAAAAAAA. Following read of 0x516 returns 0x314.
- Write with wvalid=1, wen=0 to 0x514 data 0xDEAD -> subsequent read still 0x114. Write 0x55 to 0x914 (aliases index 0x114) -> read of 0x514 returns 0x55.
- Read accepted with rready=0 for 3 cycles -> rvalid and rdata stable, arready=0 until rready=1. Back-to-back reads with rready=1 -> one response per cycle.
- Assert rst_n=0 mid-response -> rvalid=0, rdata=0 immediately (asynchronous). After release, a read of the earlier address still returns its stored data (array not cleared).
